bcd_seg_scan: RTL and testbench

- Consumer end of the binary-to-BCD path: captures a packed BCD word when the converter signals ready, and drives a time-multiplexed common-anode 7-segment display, one digit per scan slot.
- Sits between bin2bcd (source of `in` and `in_vld`) and the board display pins.
- Frame-synchronous update (no tearing), anti-ghosting dead time, leading-zero blanking, invalid-nibble indication.

---
 rtl/bcd_seg_pkg.sv | 18 +
 rtl/bcd7seg.sv | 17 +
 rtl/bcd_seg_scan.sv | 134 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared types and segment tables for the multiplexed BCD display path.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Nibbles 10..15 are not valid BCD and render as a dash.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        SEG_DASH, SEG_DASH, SEG_DASH,
        SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD nibble to active-low 7-segment pattern, with blank override.
module bcd7seg
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_LUT[nib_i];
        if (blank_i) begin
            seg_o = SEG_OFF;
        end
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed common-anode display driver: captures BCD words, swaps them in
// on frame boundaries, and scans one digit per slot with a dead-time prefix.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int unsigned DEC_W     = 8,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned BLANK_LZ  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEC_W-1:0][3:0] in,
    input  logic                  in_vld,
    output logic [6:0]            seg,
    output logic [DEC_W-1:0]      dig,
    output logic                  frame,
    output logic                  busy_upd
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DEC_W > 1) ? $clog2(DEC_W) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [IW-1:0] I_LAST  = IW'(DEC_W - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DEC_W-1:0][3:0]   pend_q, pend_d;
    logic [DEC_W-1:0][3:0]   disp_q, disp_d;
    logic                    busy_q, busy_d;
    logic                    frame_q, frame_d;
    logic [6:0]              seg_q, seg_d;
    logic [DEC_W-1:0]        dig_q, dig_d;

    logic [DEC_W-1:0]        lz_blank;
    bcd_digit_t              cur_nib;
    logic                    cur_blank;
    logic [6:0]              cur_pat;

    // Slot prescaler and digit index.
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == P_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end
        // frame is registered yet aligned with the last cycle of the frame, so it
        // is predicted from the next counter state.
        frame_d = (pre_d == P_LAST) && (idx_d == I_LAST);
    end

    // Capture and frame-synchronous display swap; a strobe on the frame cycle bypasses pending.
    always_comb begin
        pend_d = pend_q;
        busy_d = busy_q;
        disp_d = disp_q;
        if (in_vld) begin
            pend_d = in;
            busy_d = 1'b1;
        end
        if (frame_q) begin
            busy_d = 1'b0;
            if (in_vld) begin
                disp_d = in;
            end else if (busy_q) begin
                disp_d = pend_q;
            end
        end
    end

    // Leading-zero mask: scan from the most significant digit while all seen are zero.
    always_comb begin
        int unsigned k;
        logic        zero_run;
        k        = 0;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int unsigned i = 0; i < DEC_W; i++) begin
            k           = DEC_W - 1 - i;
            zero_run    = zero_run && (disp_q[k] == 4'd0);
            lz_blank[k] = (BLANK_LZ != 0) && zero_run && (k != 0);
        end
    end

    always_comb begin
        cur_nib   = disp_q[idx_q];
        cur_blank = lz_blank[idx_q];
    end

    bcd7seg u_dec (
        .nib_i   (cur_nib),
        .blank_i (cur_blank),
        .seg_o   (cur_pat)
    );

    always_comb begin
        seg_d = cur_pat;
        dig_d = '1;
        if ((pre_q >= P_BLANK) && !cur_blank) begin
            dig_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= '1;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign frame    = frame_q;
    assign busy_upd = busy_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: table of display values, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_bcd_seg_scan;

    localparam int unsigned W   = 4;
    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;
    localparam int unsigned FRM = W * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [15:0] in_w = '0;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame;
    logic        busy_upd;

    bcd_seg_scan #(
        .DEC_W     (W),
        .SCAN_DIV  (DIV),
        .BLANK_CYC (BLK),
        .BLANK_LZ  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_w),
        .in_vld   (in_vld),
        .seg      (seg),
        .dig      (dig),
        .frame    (frame),
        .busy_upd (busy_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     val;
        logic [3:0][6:0] seg;
        logic [3:0]      act;
    } vec_t;

    vec_t tbl [7];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: time since reset, display/pending values, expected outputs.
    int unsigned     m_t    = 0;
    logic [15:0]     m_disp = '0;
    logic [15:0]     m_pend = '0;
    logic            m_busy = 1'b0;
    logic [6:0]      e_seg  = 7'h7F;
    logic [3:0]      e_dig  = 4'hF;
    logic            e_frame = 1'b0;

    logic [3:0][6:0] obs_seg;
    logic [3:0]      obs_act;
    logic            saw_one3 = 1'b0;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'd0: pat = 7'h40;
            4'd1: pat = 7'h79;
            4'd2: pat = 7'h24;
            4'd3: pat = 7'h30;
            4'd4: pat = 7'h19;
            4'd5: pat = 7'h12;
            4'd6: pat = 7'h02;
            4'd7: pat = 7'h78;
            4'd8: pat = 7'h00;
            4'd9: pat = 7'h10;
            default: pat = 7'h3F;
        endcase
    endfunction

    task automatic tick(input logic r, input logic v, input logic [15:0] x);
        int unsigned p;
        int unsigned k;
        logic        bl;
        logic [3:0]  nib;
        logic [3:0]  sel;
        rst    = r;
        in_vld = v;
        in_w   = x;
        @(posedge clk);
        if (r) begin
            m_t     = 0;
            m_disp  = '0;
            m_pend  = '0;
            m_busy  = 1'b0;
            e_seg   = 7'h7F;
            e_dig   = 4'hF;
            e_frame = 1'b0;
        end else begin
            p   = m_t % DIV;
            k   = (m_t / DIV) % W;
            nib = 4'((m_disp >> (4 * k)) & 16'hF);
            bl  = (k != 0) && ((m_disp >> (4 * k)) == 16'h0);
            e_seg = bl ? 7'h7F : pat(nib);
            e_dig = (p < BLK || bl) ? 4'hF : ~(4'b0001 << k);
            if (m_t % FRM == FRM - 1) begin
                if (v) m_disp = x;
                else if (m_busy) m_disp = m_pend;
                m_busy = 1'b0;
            end else if (v) begin
                m_pend = x;
                m_busy = 1'b1;
            end
            m_t++;
            e_frame = (m_t % FRM == FRM - 1);
        end
        #1;
        vectors++;
        if ({seg, dig, frame, busy_upd} !== {e_seg, e_dig, e_frame, m_busy}) begin
            miscompares++;
            $display("FAIL outputs t=%0d: got seg=%h dig=%b frame=%b busy=%b, expected seg=%h dig=%b frame=%b busy=%b",
                     m_t, seg, dig, frame, busy_upd, e_seg, e_dig, e_frame, m_busy);
        end
        for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            if (dig === sel) begin
                obs_seg[d] = seg;
                obs_act[d] = 1'b1;
            end
        end
        if (dig === 4'b0111 && seg === 7'h79) saw_one3 = 1'b1;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 100) begin
            tick(1'b0, 1'b0, 16'h0);
            n++;
        end
        vectors++;
        if (frame !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_frame: got no frame pulse in %0d cycles, required one within %0d", n, FRM);
        end
    endtask

    // Observe one whole frame of scanning and compare each digit slot with the table.
    task automatic observe(input int i);
        tick(1'b0, 1'b0, 16'h0);
        obs_act = '0;
        obs_seg = '1;
        repeat (FRM) tick(1'b0, 1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (obs_act[d] !== tbl[i].act[d] ||
                (tbl[i].act[d] && obs_seg[d] !== tbl[i].seg[d])) begin
                miscompares++;
                $display("FAIL digit%0d of %h: got act=%b seg=%h, required act=%b seg=%h",
                         d, tbl[i].val, obs_act[d], obs_seg[d], tbl[i].act[d], tbl[i].seg[d]);
            end
        end
    endtask

    initial begin
        int          f1;
        int          f2;
        int          n;
        logic        r;
        logic        v;
        logic [31:0] x;

        tbl[0] = '{val: 16'h0042, seg: {7'h7F, 7'h7F, 7'h19, 7'h24}, act: 4'b0011};
        tbl[1] = '{val: 16'h00A1, seg: {7'h7F, 7'h7F, 7'h3F, 7'h79}, act: 4'b0011};
        tbl[2] = '{val: 16'h5678, seg: {7'h12, 7'h02, 7'h78, 7'h00}, act: 4'b1111};
        tbl[3] = '{val: 16'h0F00, seg: {7'h7F, 7'h3F, 7'h40, 7'h40}, act: 4'b0111};
        tbl[4] = '{val: 16'h1900, seg: {7'h79, 7'h10, 7'h40, 7'h40}, act: 4'b1111};
        tbl[5] = '{val: 16'h9000, seg: {7'h10, 7'h40, 7'h40, 7'h40}, act: 4'b1111};
        tbl[6] = '{val: 16'h0000, seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, act: 4'b0001};

        tick(1'b1, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0);

        // Idle after reset: frame cadence and the single "0".
        f1 = -1;
        f2 = -1;
        for (int c = 1; c <= 70; c++) begin
            tick(1'b0, 1'b0, 16'h0);
            if (frame === 1'b1) begin
                if (f1 < 0) f1 = c;
                else if (f2 < 0) f2 = c;
            end
        end
        vectors++;
        if (f1 != 31 || f2 - f1 != 32) begin
            miscompares++;
            $display("FAIL frame_cadence: got first=%0d period=%0d, required first=31 period=32", f1, f2 - f1);
        end
        wait_frame();
        observe(6);

        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b1, tbl[i].val);
            wait_frame();
            observe(i);
        end

        // Last value before the frame boundary wins.
        saw_one3 = 1'b0;
        wait_frame();
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b1, 16'h1234);
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b1, 16'h5678);
        vectors++;
        if (busy_upd !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_pending: got %b, required 1", busy_upd);
        end
        wait_frame();
        observe(2);
        vectors++;
        if (saw_one3 !== 1'b0) begin
            miscompares++;
            $display("FAIL overwritten_1234: got digit3 showing 1, required never shown");
        end

        // Strobe coincident with the frame pulse goes straight to the display.
        wait_frame();
        tick(1'b0, 1'b1, 16'h9000);
        vectors++;
        if (busy_upd !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_busy: got %b, required 0", busy_upd);
        end
        observe(5);

        // Reset mid-frame at digit 2, prescaler 5.
        n = 0;
        while (m_t % FRM != 2 * DIV + 5 && n < 100) begin
            tick(1'b0, 1'b0, 16'h0);
            n++;
        end
        tick(1'b1, 1'b0, 16'h0);
        vectors++;
        if (seg !== 7'h7F || dig !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_outputs: got seg=%h dig=%b, required seg=7f dig=1111", seg, dig);
        end
        n = 0;
        while (frame !== 1'b1 && n < 100) begin
            tick(1'b0, 1'b0, 16'h0);
            n++;
        end
        vectors++;
        if (n != 31) begin
            miscompares++;
            $display("FAIL reset_frame: got frame %0d cycles after reset, required 31", n);
        end
        observe(6);

        // Randomized traffic, including invalid nibbles and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 15) == 0);
            x = $urandom;
            x = x >> (4 * $urandom_range(0, 4));
            tick(r, v, x[15:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
